// File: rtl/fpu_dest_pkg.sv
// Shared FPU destination-tracking types.
// One entry per pipeline stage: destination, liveness, result state.
package fpu_dest_pkg;

    localparam int FP_REG_W   = 5;
    localparam int FPU_DEPTH  = 4;
    localparam int FPU_DATA_W = 32;

    typedef struct packed {
        logic [FP_REG_W-1:0]   rd;
        logic                  legal;
        logic                  done;
        logic [FPU_DATA_W-1:0] data;
    } fpu_dest_entry_t;

endpackage

// File: rtl/fpu_dest_stage.sv
// One destination-tracking entry: load/hold/clear plus a result capture port.
// Capture overrides the loaded done/data, so a result can follow its entry forward.
module fpu_dest_stage
    import fpu_dest_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_load,
    input  logic [FP_REG_W-1:0]   i_rd,
    input  logic                  i_legal,
    input  logic                  i_done,
    input  logic [FPU_DATA_W-1:0] i_data,
    input  logic                  i_cap,
    input  logic [FPU_DATA_W-1:0] i_cap_data,
    output logic [FP_REG_W-1:0]   o_rd,
    output logic                  o_legal,
    output logic                  o_done,
    output logic [FPU_DATA_W-1:0] o_data
);

    fpu_dest_entry_t r_q;
    fpu_dest_entry_t w_d;

    assign w_d = '{rd: i_rd, legal: i_legal, done: i_done, data: i_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q.legal <= 1'b0;
            r_q.done  <= 1'b0;
        end else begin
            if (i_load) begin
                r_q <= w_d;
            end
            if (i_cap) begin
                r_q.done <= 1'b1;
                r_q.data <= i_cap_data;
            end
        end
    end

    assign o_rd    = r_q.rd;
    assign o_legal = r_q.legal;
    assign o_done  = r_q.done;
    assign o_data  = r_q.data;

endmodule

// File: rtl/fpu_dest_pipe.sv
// FPU destination-tracking pipeline: four entries feeding operand forwarding
// and retiring into the FP register file from stage 4.
module fpu_dest_pipe
    import fpu_dest_pkg::*;
#(
    parameter int DATA_W = FPU_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [4:0]        issue_rd,
    output logic              issue_ready,
    input  logic              stall,
    input  logic              flush,
    input  logic              res_valid,
    input  logic [1:0]        res_stage,
    input  logic [DATA_W-1:0] res_data,
    output logic [4:0]        rdi_buf_1,
    output logic [4:0]        rdi_buf_2,
    output logic [4:0]        rdi_buf_3,
    output logic [4:0]        rdi_buf_4,
    output logic              legal_1,
    output logic              legal_2,
    output logic              legal_3,
    output logic              legal_4,
    output logic              ready_1,
    output logic              ready_2,
    output logic              ready_3,
    output logic              ready_4,
    output logic [DATA_W-1:0] data_1,
    output logic [DATA_W-1:0] data_2,
    output logic [DATA_W-1:0] data_3,
    output logic [DATA_W-1:0] data_4,
    output logic              wb_en,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              err
);

    logic [FP_REG_W-1:0]   w_rd   [FPU_DEPTH];
    logic                  w_legal[FPU_DEPTH];
    logic                  w_done [FPU_DEPTH];
    logic [FPU_DATA_W-1:0] w_data [FPU_DEPTH];
    logic [FPU_DEPTH-1:0]  w_cap;
    logic [FPU_DEPTH-1:0]  w_sel;
    logic [FPU_DATA_W-1:0] w_res_data;
    logic                  w_adv;
    logic                  w_tgt_ok;
    logic                  w_bad_cap;
    logic                  w_byp_hit;
    logic                  w_retire_bad;
    logic                  r_err;

    assign w_adv      = !stall && !flush;
    assign w_sel      = FPU_DEPTH'(1) << res_stage;
    assign w_res_data = FPU_DATA_W'(res_data);

    // Target is judged on the entry as it sits before the edge.
    assign w_tgt_ok  = res_valid && w_legal[res_stage] && !w_done[res_stage];
    assign w_bad_cap = res_valid && !w_tgt_ok;
    assign w_byp_hit = w_tgt_ok && (res_stage == 2'd3);

    genvar g;
    generate
        for (g = 0; g < FPU_DEPTH; g++) begin : g_stage
            if (g == 0) begin : g_head
                assign w_cap[g] = w_tgt_ok && stall && w_sel[g];

                fpu_dest_stage u_stage (
                    .clk        (clk),
                    .rst        (rst),
                    .i_clr      (flush),
                    .i_load     (w_adv),
                    .i_rd       (issue_rd),
                    .i_legal    (issue_valid),
                    .i_done     (1'b0),
                    .i_data     ('0),
                    .i_cap      (w_cap[g]),
                    .i_cap_data (w_res_data),
                    .o_rd       (w_rd[g]),
                    .o_legal    (w_legal[g]),
                    .o_done     (w_done[g]),
                    .o_data     (w_data[g])
                );
            end else begin : g_body
                // Stalled: capture in place; advancing: capture where the entry lands.
                assign w_cap[g] = w_tgt_ok && (stall ? w_sel[g] : w_sel[g-1]);

                fpu_dest_stage u_stage (
                    .clk        (clk),
                    .rst        (rst),
                    .i_clr      (flush),
                    .i_load     (w_adv),
                    .i_rd       (w_rd[g-1]),
                    .i_legal    (w_legal[g-1]),
                    .i_done     (w_done[g-1]),
                    .i_data     (w_data[g-1]),
                    .i_cap      (w_cap[g]),
                    .i_cap_data (w_res_data),
                    .o_rd       (w_rd[g]),
                    .o_legal    (w_legal[g]),
                    .o_done     (w_done[g]),
                    .o_data     (w_data[g])
                );
            end
        end
    endgenerate

    assign wb_en        = w_legal[3] && w_adv;
    assign wb_rd        = w_rd[3];
    assign wb_data      = w_byp_hit ? res_data : DATA_W'(w_data[3]);
    assign w_retire_bad = wb_en && !w_done[3] && !w_byp_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (!flush && (w_bad_cap || w_retire_bad)) begin
            r_err <= 1'b1;
        end
    end

    assign issue_ready = w_adv;
    assign err         = r_err;

    assign rdi_buf_1 = w_rd[0];
    assign rdi_buf_2 = w_rd[1];
    assign rdi_buf_3 = w_rd[2];
    assign rdi_buf_4 = w_rd[3];
    assign legal_1   = w_legal[0];
    assign legal_2   = w_legal[1];
    assign legal_3   = w_legal[2];
    assign legal_4   = w_legal[3];
    assign ready_1   = w_done[0];
    assign ready_2   = w_done[1];
    assign ready_3   = w_done[2];
    assign ready_4   = w_done[3];
    assign data_1    = DATA_W'(w_data[0]);
    assign data_2    = DATA_W'(w_data[1]);
    assign data_3    = DATA_W'(w_data[2]);
    assign data_4    = DATA_W'(w_data[3]);

endmodule

// File: tb/tb_fpu_dest_pipe.sv
// Directed testbench for fpu_dest_pipe.
// Each scenario task checks its own hand-computed expectations.
module tb_fpu_dest_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        stall;
    logic        flush;
    logic        res_valid;
    logic [1:0]  res_stage;
    logic [31:0] res_data;
    logic [4:0]  rdi_buf_1, rdi_buf_2, rdi_buf_3, rdi_buf_4;
    logic        legal_1, legal_2, legal_3, legal_4;
    logic        ready_1, ready_2, ready_3, ready_4;
    logic [31:0] data_1, data_2, data_3, data_4;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    fpu_dest_pipe #(.DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .stall       (stall),
        .flush       (flush),
        .res_valid   (res_valid),
        .res_stage   (res_stage),
        .res_data    (res_data),
        .rdi_buf_1   (rdi_buf_1),
        .rdi_buf_2   (rdi_buf_2),
        .rdi_buf_3   (rdi_buf_3),
        .rdi_buf_4   (rdi_buf_4),
        .legal_1     (legal_1),
        .legal_2     (legal_2),
        .legal_3     (legal_3),
        .legal_4     (legal_4),
        .ready_1     (ready_1),
        .ready_2     (ready_2),
        .ready_3     (ready_3),
        .ready_4     (ready_4),
        .data_1      (data_1),
        .data_2      (data_2),
        .data_3      (data_3),
        .data_4      (data_4),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .err         (err)
    );

    always #5 clk = ~clk;

    wire [3:0] legal = {legal_4, legal_3, legal_2, legal_1};
    wire [3:0] ready = {ready_4, ready_3, ready_2, ready_1};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; issue_valid = 1'b0; issue_rd = '0;
        stall = 1'b0; flush = 1'b0;
        res_valid = 1'b0; res_stage = '0; res_data = '0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid = 1'b1; issue_rd = rd;
        tick();
        issue_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        do_reset();
        n_checks++;
        if ({legal, ready} !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_flags got %h exp 00", {legal, ready});
        end
        n_checks++;
        if ({rdi_buf_1, rdi_buf_2, rdi_buf_3, rdi_buf_4, wb_rd} !== 25'd0) begin
            n_errors++;
            $display("FAIL reset_rd got nonzero rd outputs");
        end
        n_checks++;
        if ((data_1 | data_2 | data_3 | data_4 | wb_data) !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_data got nonzero data outputs");
        end
        n_checks++;
        if ({wb_en, err, issue_ready} !== 3'b001) begin
            n_errors++;
            $display("FAIL reset_ctl got %b exp 001", {wb_en, err, issue_ready});
        end
        stall = 1'b1; #1;
        n_checks++;
        if (issue_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL ready_stall got %b exp 0", issue_ready);
        end
        stall = 1'b0; flush = 1'b1; #1;
        n_checks++;
        if (issue_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL ready_flush got %b exp 0", issue_ready);
        end
        flush = 1'b0; #1;
    endtask

    task automatic test_single;
        do_reset();
        issue(5'd7);
        n_checks++;
        if (legal !== 4'b0001 || rdi_buf_1 !== 5'd7) begin
            n_errors++;
            $display("FAIL single_t1 got %b/%0d exp 0001/7", legal, rdi_buf_1);
        end
        tick();
        n_checks++;
        if (legal !== 4'b0010 || rdi_buf_2 !== 5'd7) begin
            n_errors++;
            $display("FAIL single_t2 got %b/%0d exp 0010/7", legal, rdi_buf_2);
        end
        res_valid = 1'b1; res_stage = 2'd1; res_data = 32'h1234_5678;
        tick();
        res_valid = 1'b0; #1;
        n_checks++;
        if (legal !== 4'b0100 || ready !== 4'b0100 || data_3 !== 32'h1234_5678) begin
            n_errors++;
            $display("FAIL single_t3 got %b %b %h exp 0100 0100 12345678",
                     legal, ready, data_3);
        end
        tick();
        n_checks++;
        if (legal !== 4'b1000 || wb_en !== 1'b1 || wb_rd !== 5'd7
            || wb_data !== 32'h1234_5678) begin
            n_errors++;
            $display("FAIL single_wb got %b %b %0d %h exp 1000 1 7 12345678",
                     legal, wb_en, wb_rd, wb_data);
        end
        tick();
        n_checks++;
        if (legal !== 4'b0000 || wb_en !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL single_done got %b %b %b exp 0000 0 0", legal, wb_en, err);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        for (int k = 1; k <= 4; k++) issue(5'(k));
        n_checks++;
        if (legal !== 4'b1111 || {rdi_buf_1, rdi_buf_2, rdi_buf_3, rdi_buf_4}
            !== {5'd4, 5'd3, 5'd2, 5'd1}) begin
            n_errors++;
            $display("FAIL b2b_fill got %b %0d %0d %0d %0d exp 1111 4 3 2 1",
                     legal, rdi_buf_1, rdi_buf_2, rdi_buf_3, rdi_buf_4);
        end
        for (int k = 1; k <= 4; k++) begin
            res_valid = 1'b1; res_stage = 2'd3; res_data = 32'h111 * k;
            #1;
            n_checks++;
            if (wb_en !== 1'b1 || wb_rd !== 5'(k) || wb_data !== 32'h111 * k) begin
                n_errors++;
                $display("FAIL b2b_wb%0d got %b %0d %h exp 1 %0d %h",
                         k, wb_en, wb_rd, wb_data, k, 32'h111 * k);
            end
            tick();
        end
        res_valid = 1'b0; #1;
        n_checks++;
        if (legal !== 4'b0000 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_end got %b %b exp 0000 0", legal, err);
        end
    endtask

    task automatic test_stall;
        do_reset();
        issue(5'd5);
        res_valid = 1'b1; res_stage = 2'd0; res_data = 32'h0000_00AA;
        tick();
        res_valid = 1'b0; #1;
        n_checks++;
        if (ready !== 4'b0010 || data_2 !== 32'hAA) begin
            n_errors++;
            $display("FAIL stall_cap got %b %h exp 0010 aa", ready, data_2);
        end
        tick(); tick();
        stall = 1'b1; #1;
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (wb_en !== 1'b0 || issue_ready !== 1'b0 || legal !== 4'b1000
                || rdi_buf_4 !== 5'd5 || ready_4 !== 1'b1 || data_4 !== 32'hAA) begin
                n_errors++;
                $display("FAIL stall_hold%0d got wb=%b ir=%b leg=%b rd=%0d d=%h",
                         c, wb_en, issue_ready, legal, rdi_buf_4, data_4);
            end
            tick();
        end
        stall = 1'b0; #1;
        n_checks++;
        if (wb_en !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'hAA) begin
            n_errors++;
            $display("FAIL stall_release got %b %0d %h exp 1 5 aa", wb_en, wb_rd, wb_data);
        end
        tick();
        n_checks++;
        if (legal !== 4'b0000 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_end got %b %b exp 0000 0", legal, err);
        end
    endtask

    task automatic test_stall_capture;
        do_reset();
        issue(5'd6);
        tick();
        stall = 1'b1;
        res_valid = 1'b1; res_stage = 2'd1; res_data = 32'h0000_0055;
        tick();
        stall = 1'b0; res_valid = 1'b0; #1;
        n_checks++;
        if (legal !== 4'b0010 || ready !== 4'b0010 || data_2 !== 32'h55) begin
            n_errors++;
            $display("FAIL stallcap_inplace got %b %b %h exp 0010 0010 55",
                     legal, ready, data_2);
        end
        tick(); tick();
        n_checks++;
        if (wb_en !== 1'b1 || wb_rd !== 5'd6 || wb_data !== 32'h55) begin
            n_errors++;
            $display("FAIL stallcap_wb got %b %0d %h exp 1 6 55", wb_en, wb_rd, wb_data);
        end
        tick();
        n_checks++;
        if (err !== 1'b0) begin
            n_errors++;
            $display("FAIL stallcap_err got %b exp 0", err);
        end
    endtask

    task automatic test_bypass;
        do_reset();
        issue(5'd9);
        tick(); tick(); tick();
        res_valid = 1'b1; res_stage = 2'd3; res_data = 32'h3F80_0000;
        #1;
        n_checks++;
        if (wb_en !== 1'b1 || wb_rd !== 5'd9 || wb_data !== 32'h3F80_0000) begin
            n_errors++;
            $display("FAIL bypass_wb got %b %0d %h exp 1 9 3f800000",
                     wb_en, wb_rd, wb_data);
        end
        tick();
        res_valid = 1'b0; #1;
        n_checks++;
        if (err !== 1'b0 || legal !== 4'b0000) begin
            n_errors++;
            $display("FAIL bypass_err got %b %b exp 0 0000", err, legal);
        end
    endtask

    task automatic test_flush;
        do_reset();
        issue(5'd1); issue(5'd2); issue(5'd3);
        n_checks++;
        if (legal !== 4'b0111) begin
            n_errors++;
            $display("FAIL flush_pre got %b exp 0111", legal);
        end
        flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd8;
        #1;
        n_checks++;
        if (issue_ready !== 1'b0 || wb_en !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_comb got ir=%b wb=%b exp 0 0", issue_ready, wb_en);
        end
        tick();
        flush = 1'b0; issue_valid = 1'b0; #1;
        n_checks++;
        if (legal !== 4'b0000 || ready !== 4'b0000 || wb_en !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_clear got %b %b %b exp 0000 0000 0", legal, ready, wb_en);
        end
        tick();
        n_checks++;
        if (legal !== 4'b0000 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_lost got %b %b exp 0000 0", legal, err);
        end
    endtask

    task automatic test_err;
        do_reset();
        res_valid = 1'b1; res_stage = 2'd2; res_data = 32'h1;
        tick();
        res_valid = 1'b0; #1;
        n_checks++;
        if (err !== 1'b1) begin
            n_errors++;
            $display("FAIL err_empty got %b exp 1", err);
        end
        tick(); tick();
        n_checks++;
        if (err !== 1'b1) begin
            n_errors++;
            $display("FAIL err_sticky got %b exp 1", err);
        end
        do_reset();
        n_checks++;
        if (err !== 1'b0) begin
            n_errors++;
            $display("FAIL err_rst got %b exp 0", err);
        end
        issue(5'd3);
        tick(); tick(); tick();
        n_checks++;
        if (wb_en !== 1'b1 || wb_rd !== 5'd3 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL err_retire_pre got %b %0d %b exp 1 3 0", wb_en, wb_rd, err);
        end
        tick();
        n_checks++;
        if (err !== 1'b1) begin
            n_errors++;
            $display("FAIL err_retire got %b exp 1", err);
        end
        tick();
        n_checks++;
        if (err !== 1'b1) begin
            n_errors++;
            $display("FAIL err_retire_sticky got %b exp 1", err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_stall_capture();
        test_bypass();
        test_flush();
        test_err();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
